// File: rtl/serial_rx_if.sv
// Byte hand-off bus between serial_rx (master) and its consumer (slave).
// One-deep valid/ready: data_out is held until data_valid & data_ready.
interface serial_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_rx.sv
// Serial receiver: start + 8 data bits (MSB first) + stop, one-deep output buffer.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_error port.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit IDLE_LEVEL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_in,
    serial_rx_if.master rx_bus,
    output logic        busy,
    output logic        frame_error,
    output logic        overrun
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic        parity_error
`endif
);

    localparam int CW          = $clog2(CLKS_PER_BIT);
    localparam bit START_LEVEL = ~IDLE_LEVEL;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
        $error("serial_rx: CLKS_PER_BIT must be even and >= 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [1:0]    sync_q;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          s;
    logic          par_fail;
    logic          frame_good;
    logic          buf_free;

    assign s = sync_q[1];

`ifdef SERIAL_RX_PARITY_EN
    logic par_q;
    assign par_fail = ^{shift_q, par_q};
`else
    assign par_fail = 1'b0;
`endif

    assign frame_good = (s == IDLE_LEVEL) && !par_fail;
    assign buf_free   = !rx_bus.data_valid || rx_bus.data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchroniser resets to the idle level so reset itself never looks like a start edge.
            sync_q            <= {2{IDLE_LEVEL}};
            state             <= ST_IDLE;
            cyc_cnt           <= '0;
            bit_cnt           <= '0;
            shift_q           <= '0;
            rx_bus.data_out   <= '0;
            rx_bus.data_valid <= 1'b0;
            busy              <= 1'b0;
            frame_error       <= 1'b0;
            overrun           <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q             <= 1'b0;
            parity_error      <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], serial_in};
            cyc_cnt <= cyc_cnt + 1'b1;
            // NOTE: pulses and the consume default first; a later non-blocking write in this block overrides them.
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            if (rx_bus.data_valid && rx_bus.data_ready)
                rx_bus.data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cyc_cnt <= '0;
                    if (s == START_LEVEL) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cyc_cnt == HALF_M1) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        if (s == START_LEVEL) begin
                            state <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (cyc_cnt == FULL_M1) begin
                        cyc_cnt <= '0;
                        shift_q <= {shift_q[6:0], s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    if (cyc_cnt == FULL_M1) begin
                        cyc_cnt <= '0;
                        par_q   <= s;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cyc_cnt == FULL_M1) begin
                        cyc_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                        parity_error <= par_fail;
`endif
                        if (s == IDLE_LEVEL) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_WAIT_IDLE;
                        end
                        // Load when free (including a same-cycle consume), else drop the new byte.
                        if (frame_good) begin
                            if (buf_free) begin
                                rx_bus.data_out   <= shift_q;
                                rx_bus.data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (s == IDLE_LEVEL) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive-side counterpart to the 8-bit parallel-in/serial-out shift register.
- Consumes its MSB-first bit stream, framed with start and stop bits, and reassembles bytes.
- Presents each byte to the downstream bus or register file through a one-deep valid/ready buffer.
- Flags glitched starts, framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- IDLE_LEVEL, 1, line level when idle; start bit = ~IDLE_LEVEL, stop bit = IDLE_LEVEL.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  asynchronous serial line (data_out of the upstream shift register).
- data_out  output  8  received byte; stable while data_valid = 1.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts the byte when data_valid & data_ready.
- busy  output  1  high in any state other than IDLE.
- frame_error  output  1  one-cycle pulse: stop bit sampled at the wrong level.
- overrun  output  1  one-cycle pulse: a good frame was dropped because the buffer was full.

Behaviour:
- Input synchronisation
  - serial_in passes through a 2-flop synchroniser; all decisions use the synchronised value s.
  - The synchroniser resets to IDLE_LEVEL.
- Reset values
  - data_out = 0x00; data_valid = 0; busy = 0; frame_error = 0; overrun = 0.
  - state = IDLE, bit counter = 0, cycle counter = 0.
  - A reset mid-frame discards the partial byte. Reception restarts only at the next start edge.
- State machine (busy = 1 in every state except IDLE)
  - IDLE: when s == ~IDLE_LEVEL, go to START and clear the cycle counter.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample s.
    - Still at the start level: go to DATA, bit counter = 0.
    - Otherwise (glitch): return to IDLE silently.
  - DATA: every CLKS_PER_BIT cycles, sample s.
    - Shift left into an 8-bit assembly register; the new bit enters the LSB, so the first bit received ends up as bit 7.
    - After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample s.
    - s == IDLE_LEVEL: the frame is good; go to IDLE.
    - Otherwise: pulse frame_error for one cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until s == IDLE_LEVEL, then go to IDLE. This stops a held break from being read as repeated frames.
- Output buffer
  - Good frame with buffer free: data_out and data_valid = 1 are registered one cycle after the stop sample. Total latency from the stop-bit midpoint to data_valid is 1 clk.
  - "Buffer free" means data_valid == 0, or data_valid & data_ready in that same cycle. A simultaneous consume and load keeps data_valid = 1 with the new byte.
  - Good frame with buffer full (data_valid = 1 and data_ready = 0): pulse overrun for one cycle. The old byte stays; the new byte is dropped.
  - data_valid falls the cycle after data_valid & data_ready unless a load happens in that same cycle.
  - data_out never changes while data_valid = 1 and data_ready = 0.
  - data_ready is ignored while data_valid = 0.
- Timing
  - Bit sampling points fall at the bit midpoints relative to the synchronised start edge, ±1 clk.
  - Counters are sized clog2(CLKS_PER_BIT).
  - A new start edge is accepted the cycle after returning to IDLE. Back-to-back frames therefore work with a one-bit stop.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples one extra bit CLKS_PER_BIT cycles after the 8th data bit.
  - Even parity is required: XOR of the 8 data bits and the parity bit must equal 0.
  - Adds output port parity_error (1 bit, resets to 0). It pulses one cycle, coincident with the stop-sample decision, when parity fails.
  - A byte failing parity is discarded, as a frame error is.
  - A frame with both faults pulses both frame_error and parity_error.
- When undefined:
  - No PARITY state and no parity_error port.
  - Frame = start + 8 data + stop.

Test Plan:
- Reset, then drive the frame for 0xA5 (bits 1,0,1,0,0,1,0,1 after the start bit), stop = 1, data_ready = 0 -> data_out = 0xA5, data_valid = 1 one cycle after the stop sample; it holds until data_ready pulses, then data_valid = 0 next cycle.
- Send 0x3C and leave it unconsumed, then send 0xFF back-to-back -> one overrun pulse, data_out stays 0x3C. Next, with data_ready held at 1, send 0x81 -> data_out = 0x81 with no overrun.
- Drive a start-level glitch lasting CLKS_PER_BIT/2 - 2 cycles -> state returns to IDLE, no data_valid, no error; a following 0x5A frame is received correctly.
- Send 0x12 with stop bit = 0 and the line held low for 3 bit times -> frame_error pulses once, data_valid stays 0, busy stays 1 until the line goes high. Then send 0x34 -> received as 0x34.
- Assert rst for 1 cycle at the 4th data bit of a frame -> all outputs 0 next cycle and the partial byte is lost. The remaining bits do not form a false frame unless a real start edge follows; a subsequent 0xC3 is received correctly.
- With SERIAL_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> accepted.
  - 0x07 with parity bit 0 -> parity_error pulses, data_valid stays 0.
